vector_gates_pipe: RTL and testbench
====================================

Name: vector_gates_pipe

Overview:
Parametrised, pipelined successor to the fixed 3-bit vector-gates block. Takes two WIDTH-bit operands and an opcode, and computes a bitwise result, a 1-bit logical result, and a concatenated inversion. It also keeps a running accumulator. Uses a valid/ready handshake on both sides, with a registered-ready skid buffer at the input. Sits between operand-producing datapath stages and downstream consumers.

Parameters:
WIDTH, 3, operand width in bits (must be 1 or more).
ACC_INIT, 0, accumulator value after reset and after ACC_CLR (WIDTH bits).

Ports:
clk  in  1  clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat; driven directly from a register.
op  in  3  opcode (see Behaviour).
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
out_valid  out  1  result beat valid.
out_ready  in  1  consumer accepts the result.
out_bitwise  out  WIDTH  bitwise result.
out_logical  out  1  logical (reduced) result.
out_not  out  2*WIDTH  {~b, ~a}, with ~a in the low half.
out_acc  out  WIDTH  accumulator value after this beat.

Behaviour:
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Opcode bitwise results (A = |a and B = |b, the reduction ORs of the operands):
  - 0 OR: a|b
  - 1 AND: a&b
  - 2 XOR: a^b
  - 3 NOR: ~(a|b)
  - 4 NAND: ~(a&b)
  - 5 XNOR: ~(a^b)
  - 6 ACC_OR: acc|a|b
  - 7 ACC_CLR: a|b
- Opcode logical results:
  - 0 OR: A||B
  - 1 AND: A&&B
  - 2 XOR: A^B
  - 3 NOR: !(A||B)
  - 4 NAND: !(A&&B)
  - 5 XNOR: !(A^B)
  - 6 ACC_OR: |(acc|a|b)
  - 7 ACC_CLR: A||B
- out_not = {~b, ~a} for every opcode.
- Accumulator update happens only on an input transfer:
  - ACC_OR: acc <= acc|a|b.
  - ACC_CLR: acc <= ACC_INIT.
  - All other opcodes: acc unchanged.
- out_acc carries the post-update acc value for the beat.
- Stage 1 is a skid buffer. in_ready = !skid_full, registered. An input transfer that occurs while stage 2 is stalled is captured in the skid register.
- Stage 2 is a result register. The result is computed combinationally from the skid output, or the bypass path, and loaded when stage 2 is empty or out_ready=1.
- Latency: 1 cycle from input transfer to out_valid when not stalled.
- Throughput: 1 beat per cycle with out_ready held high.
- Under stall: holds up to 2 beats (stage 2 + skid). in_ready drops the cycle after the skid fills. in_ready returns high the cycle after the skid drains.
- While out_valid=1 && out_ready=0, all out_* remain stable.
- Ordering: strictly in order. The accumulator is updated at input acceptance, so each beat's out_acc reflects all earlier accepted beats in order.
- Simultaneous input and output transfer with the skid empty: stage 2 loads the new beat directly, and the skid stays empty.
- Reset, including mid-stream:
  - out_valid=0, skid empty, in_ready=1 in the first cycle after reset.
  - acc=ACC_INIT.
  - out_bitwise=0, out_logical=0, out_not=0, out_acc=ACC_INIT.
  - In-flight beats are discarded.
- Ops 3..5 with WIDTH=1 reduce to scalar gates. The encoding has no illegal opcodes.

Decomposition:
- Package vector_gates_pkg holds:
  - the op_e enum with the 8 opcodes;
  - OP_W=3;
  - a function computing {bitwise, logical} from op, a, b and acc.
- Sub-module vg_skid_buf: generic data/valid/ready 1-entry skid buffer with registered ready. The datapath function and output register remain in the top module.

Test Plan:
- WIDTH=3, out_ready=1, sweep {b,a} over 0x38..0x3F then 0x00..0x15, op=0:
  - each beat: out_bitwise=a|b, out_logical=(a!=0)||(b!=0), out_not={~b,~a};
  - example a=3'b000, b=3'b111 -> out_bitwise=7, out_logical=1, out_not=6'b000111;
  - one result per cycle, 1-cycle latency.
- WIDTH=8, ops 1..5 with a=8'hF0, b=8'h3C:
  - AND=8'h30, out_logical=1;
  - XOR=8'hCC, out_logical=0;
  - NOR=8'h03, out_logical=0;
  - NAND=8'hCF, out_logical=0;
  - XNOR=8'h33, out_logical=1.
- Accumulator, WIDTH=8:
  - ACC_OR sequence a=8'h01,b=8'h00; a=8'h00,b=8'h80; a=8'h10,b=8'h00 -> out_acc=8'h01, 8'h81, 8'h91;
  - then ACC_CLR with a=8'h02,b=8'h00 -> out_acc=ACC_INIT=0, out_bitwise=8'h02.
- Backpressure:
  - out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted, in_ready=0 from the cycle after the second acceptance, outputs stable;
  - release out_ready -> beats emerge in order with no loss or duplication.
- Reset mid-stream with 2 beats buffered and acc=8'h91:
  - in the cycle after reset: out_valid=0, in_ready=1, out_acc=ACC_INIT, acc=ACC_INIT;
  - next ACC_OR with a=8'h04, b=8'h00 -> out_acc=8'h04.
- Random: 200 beats with random op/a/b/in_valid/out_ready -> every beat matches the package function reference model in order.

Source files
------------

// File: rtl/vector_gates_pkg.sv
// Opcode encoding and shared result function for the vector gates pipeline.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package vector_gates_pkg;

  localparam int OP_W  = 3;
  // Widest operand the shared function handles; narrower operands are zero-extended.
  localparam int MAX_W = 64;

  typedef enum logic [OP_W-1:0] {
    OP_OR      = 3'd0,
    OP_AND     = 3'd1,
    OP_XOR     = 3'd2,
    OP_NOR     = 3'd3,
    OP_NAND    = 3'd4,
    OP_XNOR    = 3'd5,
    OP_ACC_OR  = 3'd6,
    OP_ACC_CLR = 3'd7
  } op_e;

  // Returns {bitwise, logical}. Operands are zero-extended by the caller, so the
  // upper bitwise bits of the inverting ops are junk and get truncated away; the
  // logical result only looks at reductions, which zero-extension does not disturb.
  function automatic logic [MAX_W:0] vg_calc(
    input op_e              op,
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic [MAX_W-1:0] acc
  );
    logic [MAX_W-1:0] bw;
    logic             lg;
    logic             ra;
    logic             rb;
    ra = |a;
    rb = |b;
    bw = a | b;
    lg = ra || rb;
    case (op)
      OP_OR:      begin bw = a | b;        lg = ra || rb;     end
      OP_AND:     begin bw = a & b;        lg = ra && rb;     end
      OP_XOR:     begin bw = a ^ b;        lg = ra ^ rb;      end
      OP_NOR:     begin bw = ~(a | b);     lg = !(ra || rb);  end
      OP_NAND:    begin bw = ~(a & b);     lg = !(ra && rb);  end
      OP_XNOR:    begin bw = ~(a ^ b);     lg = !(ra ^ rb);   end
      OP_ACC_OR:  begin bw = acc | a | b;  lg = |(acc | a | b); end
      OP_ACC_CLR: begin bw = a | b;        lg = ra || rb;     end
      default:    begin bw = a | b;        lg = ra || rb;     end
    endcase
    return {bw, lg};
  endfunction

endpackage

// File: rtl/vg_skid_buf.sv
// Generic one-entry skid buffer with a registered ready; data passes straight through when empty.
// Latency: 0 cycles when empty (combinational bypass), otherwise served from the skid register.
// Backpressure: an accepted beat that downstream refuses is parked; in_rdy drops the cycle after.
module vg_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  logic          full_q, full_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          in_xfer;

  assign in_xfer = in_vld && rdy_q;
  assign in_rdy  = rdy_q;
  assign out_vld = full_q || in_xfer;
  assign out_dat = full_q ? dat_q : in_dat;

  // Park a beat when downstream stalls; release it as soon as downstream accepts.
  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (full_q) begin
      if (out_rdy) full_d = 1'b0;
    end else if (in_xfer && !out_rdy) begin
      full_d = 1'b1;
      dat_d  = in_dat;
    end
    rdy_d = !full_d;
  end

  // Skid state and the registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b1;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= rdy_d;
      dat_q  <= dat_d;
    end
  end

endmodule

// File: rtl/vector_gates_pipe.sv
// Pipelined vector gates: bitwise/logical/inverted results of two operands plus running accumulator.
// Latency: 1 cycle from input acceptance to out_valid when not stalled; 1 beat/cycle throughput.
// Backpressure: holds 2 beats (result register + skid); in_ready is a register, outputs hold while stalled.
module vector_gates_pipe
  import vector_gates_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_bitwise,
  output logic               out_logical,
  output logic [2*WIDTH-1:0] out_not,
  output logic [WIDTH-1:0]   out_acc
);

  // Each queued beat carries op, operands and the accumulator before and after
  // its own update, so a stalled beat never sees a later beat's accumulator.
  localparam int DW = OP_W + 4 * WIDTH;
  localparam int RW = WIDTH + 1;

  logic               in_xfer;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [DW-1:0]      skid_in_dat;
  logic               s_vld, s_rdy;
  logic [DW-1:0]      s_dat;
  logic [OP_W-1:0]    s_op;
  logic [WIDTH-1:0]   s_a, s_b, s_acc_pre, s_acc_post;
  logic [WIDTH:0]     calc;

  logic               out_vld_q, out_vld_d;
  logic [WIDTH-1:0]   bw_q, bw_d;
  logic               lg_q, lg_d;
  logic [2*WIDTH-1:0] not_q, not_d;
  logic [WIDTH-1:0]   acc_o_q, acc_o_d;

  // Accumulator advances at input acceptance; the beat is tagged with both snapshots.
  always_comb begin
    in_xfer = in_valid && in_ready;
    acc_d   = acc_q;
    if (in_xfer) begin
      case (op_e'(op))
        OP_ACC_OR:  acc_d = acc_q | a | b;
        OP_ACC_CLR: acc_d = ACC_INIT;
        default:    acc_d = acc_q;
      endcase
    end
    skid_in_dat = {op, a, b, acc_q, acc_d};
  end

  vg_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (skid_in_dat),
    .out_vld (s_vld),
    .out_rdy (s_rdy),
    .out_dat (s_dat)
  );

  // Result register may load whenever it is empty or its contents are leaving.
  assign s_rdy = !out_vld_q || out_ready;

  // Compute the result from the skid output (or bypass) and load the result register.
  always_comb begin
    {s_op, s_a, s_b, s_acc_pre, s_acc_post} = s_dat;
    calc = RW'(vg_calc(op_e'(s_op), MAX_W'(s_a), MAX_W'(s_b), MAX_W'(s_acc_pre)));
    out_vld_d = out_vld_q;
    bw_d      = bw_q;
    lg_d      = lg_q;
    not_d     = not_q;
    acc_o_d   = acc_o_q;
    if (s_rdy) begin
      out_vld_d = s_vld;
      if (s_vld) begin
        bw_d    = calc[WIDTH:1];
        lg_d    = calc[0];
        not_d   = {~s_b, ~s_a};
        acc_o_d = s_acc_post;
      end
    end
  end

  // Accumulator and result register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= ACC_INIT;
      out_vld_q <= 1'b0;
      bw_q      <= '0;
      lg_q      <= 1'b0;
      not_q     <= '0;
      acc_o_q   <= ACC_INIT;
    end else begin
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      bw_q      <= bw_d;
      lg_q      <= lg_d;
      not_q     <= not_d;
      acc_o_q   <= acc_o_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign out_bitwise = bw_q;
  assign out_logical = lg_q;
  assign out_not     = not_q;
  assign out_acc     = acc_o_q;

endmodule

// File: tb/tb_vector_gates_pipe.sv
// Scoreboard bench: two instances (WIDTH=8 and WIDTH=3) driven from tasks, checked by monitors.
module tb_vector_gates_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic        i8_valid, i8_ready, o8_valid, o8_ready, o8_log;
  logic [2:0]  i8_op;
  logic [7:0]  i8_a, i8_b, o8_bw, o8_acc;
  logic [15:0] o8_not;

  // WIDTH=3 instance
  logic        i3_valid, i3_ready, o3_valid, o3_ready, o3_log;
  logic [2:0]  i3_op, i3_a, i3_b, o3_bw, o3_acc;
  logic [5:0]  o3_not;

  vector_gates_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut8 (
    .clk(clk), .reset(reset), .in_valid(i8_valid), .in_ready(i8_ready),
    .op(i8_op), .a(i8_a), .b(i8_b), .out_valid(o8_valid), .out_ready(o8_ready),
    .out_bitwise(o8_bw), .out_logical(o8_log), .out_not(o8_not), .out_acc(o8_acc)
  );

  vector_gates_pipe #(.WIDTH(3), .ACC_INIT(3'd0)) dut3 (
    .clk(clk), .reset(reset), .in_valid(i3_valid), .in_ready(i3_ready),
    .op(i3_op), .a(i3_a), .b(i3_b), .out_valid(o3_valid), .out_ready(o3_ready),
    .out_bitwise(o3_bw), .out_logical(o3_log), .out_not(o3_not), .out_acc(o3_acc)
  );

  typedef struct {
    logic [7:0]  bw;
    logic        lg;
    logic [15:0] nt;
    logic [7:0]  acc;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  logic [7:0] acc8_m = 8'h00;
  logic [7:0] acc3_m = 8'h00;
  int n_cmp = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  // Reference model straight from the opcode table, on w-bit operands held in bytes.
  function automatic exp_t model(input int w, input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] acc_in,
                                 output logic [7:0] acc_out);
    exp_t e;
    logic [7:0] m;
    logic [15:0] nb;
    logic la, lb;
    m  = 8'((1 << w) - 1);
    la = ((a & m) != 0);
    lb = ((b & m) != 0);
    acc_out = acc_in;
    case (op)
      3'd0: begin e.bw = a | b;    e.lg = la || lb;    end
      3'd1: begin e.bw = a & b;    e.lg = la && lb;    end
      3'd2: begin e.bw = a ^ b;    e.lg = la != lb;    end
      3'd3: begin e.bw = ~(a | b); e.lg = !(la || lb); end
      3'd4: begin e.bw = ~(a & b); e.lg = !(la && lb); end
      3'd5: begin e.bw = ~(a ^ b); e.lg = (la == lb);  end
      3'd6: begin
        acc_out = (acc_in | a | b) & m;
        e.bw = acc_out;
        e.lg = (acc_out != 0);
      end
      default: begin e.bw = a | b; e.lg = la || lb; acc_out = 8'h00; end
    endcase
    e.bw  = e.bw & m;
    nb    = {8'h00, (~b) & m};
    e.nt  = (nb << w) | {8'h00, (~a) & m};
    e.acc = acc_out & m;
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    logic [7:0] na;
    exp_t e;
    t = 0;
    @(negedge clk);
    i8_valid = 1'b1; i8_op = op; i8_a = a; i8_b = b;
    while (!i8_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!i8_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send8_timeout in_ready=%0b required=1", i8_ready);
      i8_valid = 1'b0;
    end else begin
      e = model(8, op, a, b, acc8_m, na);
      acc8_m = na;
      e.cyc = cyc;
      q8.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic send3(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    int t;
    logic [7:0] na;
    exp_t e;
    t = 0;
    @(negedge clk);
    i3_valid = 1'b1; i3_op = op; i3_a = a; i3_b = b;
    while (!i3_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!i3_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send3_timeout in_ready=%0b required=1", i3_ready);
      i3_valid = 1'b0;
    end else begin
      e = model(3, op, {5'b0, a}, {5'b0, b}, acc3_m, na);
      acc3_m = na;
      e.cyc = cyc;
      q3.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle8();
    @(negedge clk);
    i8_valid = 1'b0;
  endtask

  task automatic idle3();
    @(negedge clk);
    i3_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q8.size() != 0 || q3.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q8.size() != 0 || q3.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout pending8=%0d pending3=%0d required=0", q8.size(), q3.size());
      q8.delete();
      q3.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Consumer-side ready for the WIDTH=8 instance, changed just after each rising edge.
  initial o8_ready = 1'b1;
  initial o3_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       o8_ready = 1'b1;
      1:       o8_ready = 1'($urandom_range(0, 1));
      default: o8_ready = 1'b0;
    endcase
  end

  // Monitor for WIDTH=8: in-order scoreboard pop on transfer, stability while stalled.
  logic        held8 = 1'b0;
  logic [32:0] snap8;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held8 = 1'b0;
    end else if (o8_valid) begin
      if (held8) begin
        n_cmp++;
        if ({o8_bw, o8_log, o8_not, o8_acc} !== snap8) begin
          n_err++;
          $display("FAIL stall_stable8 got=%h required=%h", {o8_bw, o8_log, o8_not, o8_acc}, snap8);
        end
      end
      if (o8_ready) begin
        held8 = 1'b0;
        n_cmp++;
        if (q8.size() == 0) begin
          n_err++;
          $display("FAIL out8_unexpected bw=%h acc=%h required=no beat", o8_bw, o8_acc);
        end else begin
          e = q8.pop_front();
          if (o8_bw !== e.bw || o8_log !== e.lg || o8_not !== e.nt || o8_acc !== e.acc) begin
            n_err++;
            $display("FAIL out8 got bw=%h lg=%b not=%h acc=%h required bw=%h lg=%b not=%h acc=%h",
                     o8_bw, o8_log, o8_not, o8_acc, e.bw, e.lg, e.nt, e.acc);
          end
        end
      end else begin
        held8 = 1'b1;
        snap8 = {o8_bw, o8_log, o8_not, o8_acc};
      end
    end else begin
      held8 = 1'b0;
    end
  end

  // Monitor for WIDTH=3: consumer always ready, so every beat must appear exactly one cycle after acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o3_valid && o3_ready) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL out3_unexpected bw=%h required=no beat", o3_bw);
      end else begin
        e = q3.pop_front();
        if ({5'b0, o3_bw} !== e.bw || o3_log !== e.lg || {10'b0, o3_not} !== e.nt ||
            {5'b0, o3_acc} !== e.acc || cyc != e.cyc + 1) begin
          n_err++;
          $display("FAIL out3 got bw=%h lg=%b not=%h acc=%h cyc=%0d required bw=%h lg=%b not=%h acc=%h cyc=%0d",
                   o3_bw, o3_log, o3_not, o3_acc, cyc, e.bw, e.lg, e.nt, e.acc, e.cyc + 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired required=run completes");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    logic chk_next;
    logic [5:0] vv;
    reset = 1'b1;
    i8_valid = 1'b0; i8_op = 3'd0; i8_a = 8'h00; i8_b = 8'h00;
    i3_valid = 1'b0; i3_op = 3'd0; i3_a = 3'd0; i3_b = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state of both instances
    chk("rst8_out_valid", 32'(o8_valid), 32'd0);
    chk("rst8_in_ready",  32'(i8_ready), 32'd1);
    chk("rst8_outputs",   32'({o8_bw, o8_log, o8_not}), 32'd0);
    chk("rst8_out_acc",   32'(o8_acc), 32'd0);
    chk("rst3_out_valid", 32'(o3_valid), 32'd0);
    chk("rst3_in_ready",  32'(i3_ready), 32'd1);
    chk("rst3_outputs",   32'({o3_bw, o3_log, o3_not, o3_acc}), 32'd0);

    // WIDTH=3 OR sweep of {b,a}, back to back
    for (int v = 8'h38; v <= 8'h3F; v++) begin
      vv = 6'(v);
      send3(3'd0, vv[2:0], vv[5:3]);
    end
    for (int v = 0; v <= 8'h15; v++) begin
      vv = 6'(v);
      send3(3'd0, vv[2:0], vv[5:3]);
    end
    idle3();
    drain();

    // WIDTH=8 ops 1..5 on fixed operands
    for (int o = 1; o <= 5; o++) send8(3'(o), 8'hF0, 8'h3C);
    idle8();
    drain();

    // Accumulator build-up and clear
    send8(3'd6, 8'h01, 8'h00);
    send8(3'd6, 8'h00, 8'h80);
    send8(3'd6, 8'h10, 8'h00);
    send8(3'd7, 8'h02, 8'h00);
    idle8();
    drain();

    // Backpressure: consumer stalled 5 cycles, producer always offering
    rdy_mode = 2;
    @(negedge clk);
    acc_cnt = 0;
    chk_next = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i8_op = 3'd2; i8_a = 8'(8'h21 + acc_cnt); i8_b = 8'h0F; i8_valid = 1'b1;
      if (i8_ready) begin
        logic [7:0] na;
        exp_t e;
        e = model(8, i8_op, i8_a, i8_b, acc8_m, na);
        acc8_m = na;
        q8.push_back(e);
        acc_cnt++;
        if (acc_cnt == 2) chk_next = 1'b1;
      end
      @(negedge clk);
      if (chk_next) begin
        chk("bp_in_ready_drop", 32'(i8_ready), 32'd0);
        chk_next = 1'b0;
      end
    end
    i8_valid = 1'b0;
    chk("bp_accepted", 32'(acc_cnt), 32'd2);
    chk("bp_out_valid", 32'(o8_valid), 32'd1);
    rdy_mode = 0;
    drain();

    // Reset with two beats buffered and accumulator at 0x91
    send8(3'd6, 8'h10, 8'h00);
    idle8();
    drain();
    rdy_mode = 2;
    @(negedge clk);
    send8(3'd6, 8'h01, 8'h00);
    send8(3'd6, 8'h00, 8'h80);
    idle8();
    reset = 1'b1;
    q8.delete();
    q3.delete();
    acc8_m = 8'h00;
    acc3_m = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(o8_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(i8_ready), 32'd1);
    chk("mid_rst_out_acc",   32'(o8_acc), 32'd0);
    chk("mid_rst_outputs",   32'({o8_bw, o8_log, o8_not}), 32'd0);
    rdy_mode = 0;
    send8(3'd6, 8'h04, 8'h00);
    idle8();
    drain();

    // Random traffic with random consumer readiness
    rdy_mode = 1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) idle8();
      send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    end
    idle8();
    rdy_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
